xbar_scan_sched: RTL and testbench

Command-driven scheduler for the 30x30 crossbar row/column selection path. It parses 3-byte command frames from the UART receiver and issues (row, col) selections to the shift-register/latch driver over a valid/ready handshake. It holds each cell for a programmable dwell time and supports single-cell select, raster scan and abort. It sits between the UART RX and the shift-register driver, replacing direct byte-pair addressing.

---
 rtl/xbar_scan_sched.sv | 245 ++++++++++++++++++++++++
 tb/tb_xbar_scan_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_scan_sched.sv
// xbar_scan_sched: UART command parser and (row, col) scheduler
// feeding the crossbar shift-register driver over valid/ready.

module xbar_scan_sched #(
   parameter int N_ROW     = 30,
   parameter int N_COL     = 30,
   parameter int DWELL_W   = 16,
   parameter int DWELL_DEF = 1000,
   parameter int TO_W      = 20
) (
   input  logic       clk1,
   input  logic       reset,
   input  logic       rx_done,
   input  logic [7:0] rx_data,
   output logic       sel_valid,
   output logic [4:0] sel_row,
   output logic [4:0] sel_col,
   input  logic       sel_ready,
   input  logic       drv_done,
   output logic       busy,
   output logic       scan_done,
   output logic       err
);

   localparam logic [7:0] OP_DWELL  = 8'h01;
   localparam logic [7:0] OP_SINGLE = 8'h02;
   localparam logic [7:0] OP_SCAN   = 8'h03;
   localparam logic [7:0] OP_ABORT  = 8'hFF;

   localparam logic [4:0] ROW_MAX = 5'(N_ROW);
   localparam logic [4:0] COL_MAX = 5'(N_COL);

   localparam logic [DWELL_W-1:0] DW_ONE = DWELL_W'(1);
   localparam logic [DWELL_W-1:0] DW_RST = DWELL_W'(DWELL_DEF);

   // last idle cycle before a partial frame is dropped
   localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DWELL,
      S_NEXT
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [1:0]         r_pos;
   logic [7:0]         r_op;
   logic [7:0]         r_arg1;
   logic [7:0]         r_arg2;
   logic               r_frm;
   logic [TO_W-1:0]    r_to;

   logic [DWELL_W-1:0] r_dwell;
   logic [DWELL_W-1:0] r_cnt;
   logic [4:0]         r_row;
   logic [4:0]         r_col;
   logic [4:0]         r_row_end;
   logic [4:0]         r_col_end;
   logic               r_scan;
   logic               r_err;

   logic               w_at0;
   logic               w_abort;
   logic               w_op_ok;
   logic               w_bad_op;
   logic [4:0]         w_ia;
   logic [4:0]         w_ib;
   logic               w_idx_ok;
   logic               w_is_dw;
   logic               w_is_cmd;
   logic               w_accept;
   logic               w_reject;
   logic               w_last;
   logic [15:0]        w_dw_word;
   logic [DWELL_W-1:0] w_cnt_load;

   assign w_at0    = rx_done && (r_pos == 2'd0);
   assign w_abort  = w_at0 && (rx_data == OP_ABORT);
   assign w_op_ok  = (rx_data == OP_DWELL)  ||
                     (rx_data == OP_SINGLE) ||
                     (rx_data == OP_SCAN);
   assign w_bad_op = w_at0 && !w_abort && !w_op_ok;

   assign w_ia     = r_arg1[4:0];
   assign w_ib     = r_arg2[4:0];
   assign w_idx_ok = (w_ia != 5'd0) && (w_ia <= COL_MAX) &&
                     (w_ib != 5'd0) && (w_ib <= ROW_MAX);

   assign w_is_dw  = r_frm && (r_op == OP_DWELL);
   assign w_is_cmd = r_frm &&
                     ((r_op == OP_SINGLE) || (r_op == OP_SCAN));
   assign w_accept = w_is_cmd && w_idx_ok && (r_state == S_IDLE);
   assign w_reject = w_is_cmd && !w_accept;

   assign w_last   = !r_scan ||
                     ((r_col == r_col_end) && (r_row == r_row_end));

   assign w_dw_word  = {r_arg1, r_arg2};
   assign w_cnt_load = (r_dwell == '0) ? DW_ONE : r_dwell;

   assign sel_row = r_row;
   assign sel_col = r_col;
   assign err     = r_err;

   // byte framing: position counter, frame capture, inter-byte timeout
   always_ff @(posedge clk1) begin
      if (reset) begin
         r_pos  <= 2'd0;
         r_op   <= 8'h00;
         r_arg1 <= 8'h00;
         r_arg2 <= 8'h00;
         r_frm  <= 1'b0;
         r_to   <= '0;
      end else begin
         r_frm <= 1'b0;
         if (rx_done) begin
            r_to <= '0;
            case (r_pos)
               2'd0: begin
                  if (w_op_ok) begin
                     r_op  <= rx_data;
                     r_pos <= 2'd1;
                  end
               end
               2'd1: begin
                  r_arg1 <= rx_data;
                  r_pos  <= 2'd2;
               end
               2'd2: begin
                  r_arg2 <= rx_data;
                  r_pos  <= 2'd0;
                  r_frm  <= 1'b1;
               end
               default: r_pos <= 2'd0;
            endcase
         end else if (r_pos != 2'd0) begin
            if (r_to == TO_LAST) begin
               r_pos <= 2'd0;
               r_to  <= '0;
            end else begin
               r_to <= r_to + 1'b1;
            end
         end else begin
            r_to <= '0;
         end
      end
   end

   // sticky error: bad opcode or dropped command sets, accepted command clears
   always_ff @(posedge clk1) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (w_bad_op || w_reject) begin
         r_err <= 1'b1;
      end else if (w_accept) begin
         r_err <= 1'b0;
      end
   end

   // scheduler state register
   always_ff @(posedge clk1) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next state and handshake outputs; abort overrides everything
   always_comb begin
      w_state_nxt = r_state;
      sel_valid   = 1'b0;
      busy        = 1'b1;
      scan_done   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (w_accept) w_state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            sel_valid = 1'b1;
            if (sel_ready) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (drv_done) w_state_nxt = S_DWELL;
         end
         S_DWELL: begin
            if (r_cnt <= DW_ONE) w_state_nxt = S_NEXT;
         end
         S_NEXT: begin
            scan_done   = w_last && !w_abort;
            w_state_nxt = w_last ? S_IDLE : S_ISSUE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_abort) w_state_nxt = S_IDLE;
   end

   // dwell setting, cell coordinates and dwell countdown
   always_ff @(posedge clk1) begin
      if (reset) begin
         r_dwell   <= DW_RST;
         r_cnt     <= '0;
         r_row     <= 5'd0;
         r_col     <= 5'd0;
         r_row_end <= 5'd0;
         r_col_end <= 5'd0;
         r_scan    <= 1'b0;
      end else begin
         if (w_is_dw) begin
            r_dwell <= DWELL_W'(w_dw_word);
         end
         if (w_accept) begin
            r_scan <= (r_op == OP_SCAN);
            if (r_op == OP_SCAN) begin
               r_col     <= 5'd1;
               r_row     <= 5'd1;
               r_col_end <= w_ia;
               r_row_end <= w_ib;
            end else begin
               r_col <= w_ia;
               r_row <= w_ib;
            end
         end
         if ((r_state == S_WAIT) && drv_done && !w_abort) begin
            r_cnt <= w_cnt_load;
         end else if (r_state == S_DWELL) begin
            r_cnt <= r_cnt - DW_ONE;
         end
         if ((r_state == S_NEXT) && !w_last && !w_abort) begin
            if (r_col < r_col_end) begin
               r_col <= r_col + 5'd1;
            end else begin
               r_col <= 5'd1;
               r_row <= r_row + 5'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_xbar_scan_sched.sv
// tb_xbar_scan_sched: directed command frames against a cell-list
// model of the scheduler, checked every cycle by a monitor.

module tb_xbar_scan_sched;

   localparam int TO_W = 8;

   logic       clk1 = 1'b0;
   logic       reset;
   logic       rx_done;
   logic [7:0] rx_data;
   logic       sel_valid;
   logic [4:0] sel_row;
   logic [4:0] sel_col;
   logic       sel_ready;
   logic       drv_done = 1'b0;
   logic       busy;
   logic       scan_done;
   logic       err;

   xbar_scan_sched #(.TO_W(TO_W)) dut (
      .clk1      (clk1),
      .reset     (reset),
      .rx_done   (rx_done),
      .rx_data   (rx_data),
      .sel_valid (sel_valid),
      .sel_row   (sel_row),
      .sel_col   (sel_col),
      .sel_ready (sel_ready),
      .drv_done  (drv_done),
      .busy      (busy),
      .scan_done (scan_done),
      .err       (err)
   );

   always #5 clk1 = ~clk1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // model: ordered cells still to be transferred, pending completions
   logic [9:0] exp_q[$];
   int exp_done = 0;
   int m_dwell  = 1000;

   int n_xfer   = 0;
   int n_done   = 0;
   int last_gap = 0;
   int t_drv    = 0;
   int d_exp    = 0;
   bit pend     = 0;
   bit armed    = 0;
   bit prev_v   = 0;
   bit last_v   = 0;
   logic [4:0] prev_r = 0;
   logic [4:0] prev_c = 0;

   always @(posedge clk1) cyc <= cyc + 1;

   // driver model: drv_done three cycles after each transfer
   always begin
      @(negedge clk1);
      if (sel_valid && sel_ready) begin
         @(posedge clk1);
         repeat (2) @(posedge clk1);
         #1 drv_done = 1'b1;
         @(posedge clk1);
         #1 drv_done = 1'b0;
      end
   end

   // per-cycle comparison of the DUT against the model
   always @(negedge clk1) begin
      if (!reset) begin
         if (prev_v && sel_valid) begin
            checks++;
            if (sel_row != prev_r || sel_col != prev_c) begin
               errors++;
               $display("FAIL hold: col/row %0d/%0d changed from %0d/%0d",
                        sel_col, sel_row, prev_c, prev_r);
            end
         end
         if (sel_valid && !last_v && armed) begin
            checks++;
            last_gap = cyc - t_drv;
            armed = 0;
            if (last_gap != d_exp + 2) begin
               errors++;
               $display("FAIL dwell_next: gap %0d expected %0d",
                        last_gap, d_exp + 2);
            end
         end
         if (sel_valid && sel_ready) begin
            checks++;
            n_xfer++;
            pend = 1;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL xfer: unexpected col %0d row %0d",
                        sel_col, sel_row);
            end else begin
               if ({sel_col, sel_row} != exp_q[0]) begin
                  errors++;
                  $display("FAIL xfer: got col %0d row %0d expected col %0d row %0d",
                           sel_col, sel_row, exp_q[0][9:5], exp_q[0][4:0]);
               end
               void'(exp_q.pop_front());
            end
         end
         if (drv_done && pend) begin
            pend = 0;
            armed = 1;
            t_drv = cyc;
            d_exp = (m_dwell == 0) ? 1 : m_dwell;
         end
         if (scan_done) begin
            checks++;
            n_done++;
            if (exp_done == 0 || exp_q.size() != 0) begin
               errors++;
               $display("FAIL done: pulse with %0d cells left, %0d completions due",
                        exp_q.size(), exp_done);
            end else begin
               exp_done--;
            end
            if (armed) begin
               checks++;
               last_gap = cyc - t_drv;
               armed = 0;
               if (last_gap != d_exp + 1) begin
                  errors++;
                  $display("FAIL dwell_done: gap %0d expected %0d",
                           last_gap, d_exp + 1);
               end
            end
         end
         prev_v = sel_valid && !sel_ready;
         prev_r = sel_row;
         prev_c = sel_col;
         last_v = sel_valid;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk1);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk1);
      #1 rx_done = 1'b1;
      rx_data = b;
      @(posedge clk1);
      #1 rx_done = 1'b0;
      rx_data = 8'h00;
   endtask

   task automatic send3(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c);
      send(a);
      send(b);
      send(c);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      repeat (3) @(posedge clk1);
      while (busy && n < 20000) begin
         @(posedge clk1);
         n++;
      end
      #1;
      chk(nm, int'(busy), 0);
   endtask

   task automatic expect_single(input int c, input int r);
      exp_q.push_back({5'(c), 5'(r)});
      exp_done++;
   endtask

   task automatic expect_scan(input int ce, input int re);
      for (int r = 1; r <= re; r++)
         for (int c = 1; c <= ce; c++)
            exp_q.push_back({5'(c), 5'(r)});
      exp_done++;
   endtask

   task automatic flush();
      exp_q.delete();
      exp_done = 0;
      pend = 0;
      armed = 0;
   endtask

   logic [7:0] bad [4][3];
   int         blen[4];

   initial begin
      int base;
      int n;
      bad = '{'{8'h02, 8'h00, 8'h05}, '{8'h02, 8'h1F, 8'h01},
              '{8'h07, 8'h00, 8'h00}, '{8'h03, 8'h01, 8'h1F}};
      blen = '{3, 3, 1, 3};
      reset = 1'b1;
      rx_done = 1'b0;
      rx_data = 8'h00;
      sel_ready = 1'b1;
      cycles(3);
      chk("rst_valid", int'(sel_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(scan_done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_rowcol", int'({sel_row, sel_col}), 0);
      reset = 1'b0;
      cycles(2);

      expect_single(5, 7);
      send3(8'h02, 8'h05, 8'h07);
      wait_idle("single_idle");
      chk("single_xfers", n_xfer, 1);
      chk("single_done", n_done, 1);
      chk("single_dwell_gap", last_gap, 1001);

      send3(8'h01, 8'h00, 8'h04);
      m_dwell = 4;
      expect_scan(3, 2);
      send3(8'h03, 8'h03, 8'h02);
      wait_idle("scan_idle");
      chk("scan_xfers", n_xfer, 7);
      chk("scan_done_cnt", n_done, 2);
      chk("scan_dwell_gap", last_gap, 5);

      sel_ready = 1'b0;
      expect_single(9, 10);
      send3(8'h02, 8'h09, 8'h0A);
      cycles(50);
      chk("stall_valid", int'(sel_valid), 1);
      chk("stall_col", int'(sel_col), 9);
      chk("stall_row", int'(sel_row), 10);
      chk("stall_noxfer", n_xfer, 7);
      sel_ready = 1'b1;
      wait_idle("stall_idle");
      chk("stall_xfers", n_xfer, 8);

      sel_ready = 1'b0;
      expect_single(4, 4);
      send3(8'h02, 8'h04, 8'h04);
      cycles(4);
      chk("wd_valid", int'(sel_valid), 1);
      flush();
      send(8'hFF);
      chk("wd_valid_drop", int'(sel_valid), 0);
      chk("wd_busy", int'(busy), 0);
      sel_ready = 1'b1;
      cycles(5);
      chk("wd_xfers", n_xfer, 8);

      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < blen[i]; k++) send(bad[i][k]);
         cycles(2);
         chk("bad_err", int'(err), 1);
         chk("bad_busy", int'(busy), 0);
         expect_single(1, 1);
         send3(8'h02, 8'h01, 8'h01);
         cycles(2);
         chk("good_err_clr", int'(err), 0);
         wait_idle("good_idle");
      end
      chk("bad_xfers", n_xfer, 12);

      base = n_xfer;
      expect_scan(30, 30);
      send3(8'h03, 8'h1E, 8'h1E);
      n = 0;
      while (n_xfer < base + 34 && n < 5000) begin
         @(posedge clk1);
         n++;
      end
      #1;
      chk("abort_reach", n_xfer, base + 34);
      flush();
      base = n_done;
      send(8'hFF);
      chk("abort_busy", int'(busy), 0);
      chk("abort_valid", int'(sel_valid), 0);
      cycles(20);
      chk("abort_noxfer", n_xfer, 12 + 34);
      chk("abort_nodone", n_done, base);
      expect_single(2, 2);
      send3(8'h02, 8'h02, 8'h02);
      wait_idle("post_abort_idle");

      send(8'h02);
      send(8'h05);
      cycles((1 << TO_W) + 8);
      expect_single(3, 3);
      send3(8'h02, 8'h03, 8'h03);
      wait_idle("timeout_idle");
      chk("timeout_err", int'(err), 0);

      expect_scan(2, 2);
      send3(8'h03, 8'h02, 8'h02);
      cycles(3);
      send3(8'h03, 8'h01, 8'h01);
      cycles(2);
      chk("busy_rej_err", int'(err), 1);
      chk("busy_rej_busy", int'(busy), 1);
      wait_idle("busy_rej_idle");

      send3(8'h01, 8'h00, 8'hFF);
      m_dwell = 255;
      expect_single(30, 30);
      send3(8'h02, 8'h1E, 8'h1E);
      wait_idle("dw255_idle");
      chk("dw255_gap", last_gap, 256);

      send3(8'h01, 8'h00, 8'h00);
      m_dwell = 0;
      expect_single(1, 30);
      send3(8'h02, 8'h01, 8'h1E);
      wait_idle("dw0_idle");
      chk("dw0_gap", last_gap, 2);

      cycles(5);
      chk("left_cells", exp_q.size(), 0);
      chk("left_done", exp_done, 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
